// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
//   CDB        : one completion broadcast (valid + payload).
//   NUM_FU     : number of functional units competing for the buses.
//   FU_*       : requester index of each functional unit.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU = 4;

    localparam logic [1:0] FU_ALU0   = 2'd0;
    localparam logic [1:0] FU_ALU1   = 2'd1;
    localparam logic [1:0] FU_MULT   = 2'd2;
    localparam logic [1:0] FU_BRANCH = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] FU_result;
        logic [5:0]  PRN;
        logic [4:0]  ROB_index;
        logic        mispredict;
        logic        thread_id;
    } CDB;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational two-winner round-robin picker.
//   req          : per-FU request vector (held entries).
//   rr_ptr       : index with highest priority this cycle.
//   first/second : winning indices in rotation order starting at rr_ptr.
//   first_valid/second_valid : the corresponding winner exists.
//   grant        : one-hot-or-two-hot vector of the winners.
module rr_pick2
    import cdb_arbiter_pkg::*;
(
    input  logic [NUM_FU-1:0] req,
    input  logic [1:0]        rr_ptr,
    output logic [1:0]        first,
    output logic [1:0]        second,
    output logic              first_valid,
    output logic              second_valid,
    output logic [NUM_FU-1:0] grant
);

    logic [1:0] idx;

    always_comb begin
        first        = '0;
        second       = '0;
        first_valid  = 1'b0;
        second_valid = 1'b0;
        grant        = '0;
        idx          = '0;
        // Walk the ring starting at rr_ptr; the 2-bit index wraps naturally.
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = rr_ptr + 2'(k);
            if (req[idx]) begin
                if (!first_valid) begin
                    first       = idx;
                    first_valid = 1'b1;
                    grant[idx]  = 1'b1;
                end else if (!second_valid) begin
                    second       = idx;
                    second_valid = 1'b1;
                    grant[idx]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Schedules functional-unit completions onto two registered CDBs.
//   clock, reset        : clock; asynchronous active-low reset.
//   fu_result           : per-FU completion (valid = request).
//   fu_ready            : FU may present a new result this cycle.
//   branch_mispredict_* : flush all held results, suppress next CDB load.
//   CDB_0 / CDB_1       : first / second grant, registered.
//   held_valid_debug    : holding-register occupancy.
//   rr_ptr_debug        : current highest-priority FU index.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  CDB [NUM_FU-1:0]   fu_result,
    output logic [NUM_FU-1:0] fu_ready,
    input  logic              branch_mispredict_0,
    input  logic              branch_mispredict_1,
    output CDB                CDB_0,
    output CDB                CDB_1,
    output logic [NUM_FU-1:0] held_valid_debug,
    output logic [1:0]        rr_ptr_debug
);

    CDB [NUM_FU-1:0]   hold_q, hold_d;
    CDB                cdb0_q, cdb0_d;
    CDB                cdb1_q, cdb1_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0] held_valid;
    logic [NUM_FU-1:0] grant;
    logic [1:0]        first, second;
    logic              first_valid, second_valid;
    logic              flush;

    always_comb begin
        held_valid = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            held_valid[i] = hold_q[i].valid;
        end
    end

    rr_pick2 u_pick (
        .req          (held_valid),
        .rr_ptr       (rr_ptr_q),
        .first        (first),
        .second       (second),
        .first_valid  (first_valid),
        .second_valid (second_valid),
        .grant        (grant)
    );

    assign flush = branch_mispredict_0 | branch_mispredict_1;

    // A granted entry may be refilled in the same cycle it drains.
    assign fu_ready = ~held_valid | grant;

    always_comb begin
        hold_d = hold_q;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                hold_d[i].valid = 1'b0;
            end
            if (flush) begin
                hold_d[i].valid = 1'b0;
            end else if (fu_result[i].valid && fu_ready[i]) begin
                hold_d[i] = fu_result[i];
            end
        end
    end

    // Invalid outputs keep their previous payload; only valid drops.
    always_comb begin
        cdb0_d       = cdb0_q;
        cdb0_d.valid = 1'b0;
        cdb1_d       = cdb1_q;
        cdb1_d.valid = 1'b0;
        if (!flush && first_valid) begin
            cdb0_d       = hold_q[first];
            cdb0_d.valid = 1'b1;
        end
        if (!flush && second_valid) begin
            cdb1_d       = hold_q[second];
            cdb1_d.valid = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!flush) begin
            if (second_valid) begin
                rr_ptr_d = second + 2'd1;
            end else if (first_valid) begin
                rr_ptr_d = first + 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q   <= '0;
            cdb0_q   <= '0;
            cdb1_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            hold_q   <= hold_d;
            cdb0_q   <= cdb0_d;
            cdb1_q   <= cdb1_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign CDB_0            = cdb0_q;
    assign CDB_1            = cdb1_q;
    assign held_valid_debug = held_valid;
    assign rr_ptr_debug     = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    CDB [3:0]    fu_in;
    logic [3:0]  fu_ready;
    logic        bm0, bm1;
    CDB          CDB_0, CDB_1;
    logic [3:0]  held_valid_debug;
    logic [1:0]  rr_ptr_debug;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter dut (
        .clock               (clock),
        .reset               (reset),
        .fu_result           (fu_in),
        .fu_ready            (fu_ready),
        .branch_mispredict_0 (bm0),
        .branch_mispredict_1 (bm1),
        .CDB_0               (CDB_0),
        .CDB_1               (CDB_1),
        .held_valid_debug    (held_valid_debug),
        .rr_ptr_debug        (rr_ptr_debug)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       mv [4];
    CDB         mh [4];
    int         mptr;
    CDB         m0, m1;

    // Held FUs listed in order of rotation distance from the pointer.
    function automatic void mpick(output int n, output int f, output int s);
        int order[$];
        order = {};
        for (int d = 0; d < 4; d++) begin
            if (mv[(mptr + d) % 4]) order.push_back((mptr + d) % 4);
        end
        n = order.size();
        f = (n >= 1) ? order[0] : 0;
        s = (n >= 2) ? order[1] : 0;
    endfunction

    function automatic logic [3:0] mready();
        int n, f, s;
        logic [3:0] r;
        mpick(n, f, s);
        for (int i = 0; i < 4; i++) r[i] = !mv[i];
        if (n >= 1) r[f] = 1'b1;
        if (n >= 2) r[s] = 1'b1;
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 1'b0;
                mh[i] = '0;
            end
            mptr = 0;
            m0   = '0;
            m1   = '0;
        end else begin
            int n, f, s;
            logic [3:0] rdy;
            logic fl;
            mpick(n, f, s);
            rdy = mready();
            fl  = bm0 | bm1;
            if (fl) begin
                m0.valid = 1'b0;
                m1.valid = 1'b0;
            end else begin
                if (n >= 1) begin m0 = mh[f]; m0.valid = 1'b1; end else m0.valid = 1'b0;
                if (n >= 2) begin m1 = mh[s]; m1.valid = 1'b1; end else m1.valid = 1'b0;
                if (n >= 2) mptr = (s + 1) % 4;
                else if (n == 1) mptr = (f + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                if ((n >= 1 && f == i) || (n >= 2 && s == i)) mv[i] = 1'b0;
                if (fl) mv[i] = 1'b0;
                else if (fu_in[i].valid && rdy[i]) begin
                    mv[i] = 1'b1;
                    mh[i] = fu_in[i];
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    int lowcnt [4] = '{0, 0, 0, 0};

    always @(negedge clock) begin
        logic [3:0] mvv;
        for (int i = 0; i < 4; i++) mvv[i] = mv[i];
        check("fu_ready", 64'(fu_ready), 64'(mready()));
        check("CDB_0", 64'(CDB_0), 64'(m0));
        check("CDB_1", 64'(CDB_1), 64'(m1));
        check("held_valid", 64'(held_valid_debug), 64'(mvv));
        check("rr_ptr", 64'(rr_ptr_debug), 64'(mptr));
        for (int i = 0; i < 4; i++) begin
            lowcnt[i] = fu_ready[i] ? 0 : lowcnt[i] + 1;
            check("ready_low_run_le1", 64'(lowcnt[i] > 1), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    function automatic CDB mk(input logic [5:0] prn, input logic [31:0] res);
        CDB c;
        c           = '0;
        c.valid     = 1'b1;
        c.PRN       = prn;
        c.FU_result = res;
        c.ROB_index = 5'(prn);
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        fu_in = '0;
        bm0   = 1'b0;
        bm1   = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        logic [5:0] mprn;
        fu_in = '0;
        bm0   = 1'b0;
        bm1   = 1'b0;
        reset = 1'b0;
        #2;
        check("rst_fu_ready", 64'(fu_ready), 64'hF);
        check("rst_CDB_0", 64'(CDB_0), 64'd0);
        check("rst_CDB_1", 64'(CDB_1), 64'd0);
        check("rst_rr_ptr", 64'(rr_ptr_debug), 64'd0);
        check("rst_held", 64'(held_valid_debug), 64'd0);
        tick();
        reset = 1'b1;

        // Single ALU0 result: broadcast two edges after presentation.
        fu_in[0] = mk(6'd5, 32'd100);
        check("s1_ready_pre", 64'(fu_ready), 64'hF);
        tick();
        fu_in = '0;
        check("s1_ready_held", 64'(fu_ready), 64'hF);
        tick();
        check("s1_cdb0_valid", 64'(CDB_0.valid), 64'd1);
        check("s1_cdb0_prn", 64'(CDB_0.PRN), 64'd5);
        check("s1_cdb0_res", 64'(CDB_0.FU_result), 64'd100);
        check("s1_cdb1_valid", 64'(CDB_1.valid), 64'd0);
        check("s1_rr_ptr", 64'(rr_ptr_debug), 64'd1);

        // All four at once from rr_ptr=0.
        do_reset();
        for (int i = 0; i < 4; i++) fu_in[i] = mk(6'(10 + i), 32'(1000 + i));
        tick();
        fu_in = '0;
        check("s2_ready_c1", 64'(fu_ready), 64'b0011);
        tick();
        check("s2_cdb0_prn_a", 64'(CDB_0.PRN), 64'd10);
        check("s2_cdb1_prn_a", 64'(CDB_1.PRN), 64'd11);
        check("s2_rr_a", 64'(rr_ptr_debug), 64'd2);
        check("s2_ready_c2", 64'(fu_ready), 64'hF);
        tick();
        check("s2_cdb0_prn_b", 64'(CDB_0.PRN), 64'd12);
        check("s2_cdb1_prn_b", 64'(CDB_1.PRN), 64'd13);
        check("s2_valids_b", 64'({CDB_0.valid, CDB_1.valid}), 64'b11);
        check("s2_rr_b", 64'(rr_ptr_debug), 64'd0);
        tick();
        check("s2_drained", 64'(held_valid_debug), 64'd0);

        // Mult presents continuously, others once; the model checks each cycle.
        do_reset();
        mprn = 6'd20;
        fu_in[0] = mk(6'd1, 32'd11);
        fu_in[1] = mk(6'd2, 32'd22);
        fu_in[3] = mk(6'd3, 32'd33);
        fu_in[2] = mk(mprn, 32'd500);
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            r = fu_ready;
            tick();
            for (int i = 0; i < 4; i++) begin
                if (i != 2 && r[i]) fu_in[i] = '0;
            end
            if (r[2]) begin
                mprn = mprn + 6'd1;
                fu_in[2] = mk(mprn, 32'(500 + c + 1));
            end
        end
        fu_in = '0;
        tick();
        tick();
        tick();
        check("s3_drained", 64'(held_valid_debug), 64'd0);

        // Fill every hold with rr_ptr moved to 2, then flush via mispredict_1.
        do_reset();
        for (int i = 0; i < 4; i++) fu_in[i] = mk(6'(30 + i), 32'(i));
        tick();
        fu_in = '0;
        fu_in[0] = mk(6'd40, 32'd40);
        fu_in[1] = mk(6'd41, 32'd41);
        tick();
        fu_in = '0;
        check("s4_full", 64'(held_valid_debug), 64'hF);
        check("s4_rr_pre", 64'(rr_ptr_debug), 64'd2);
        bm1 = 1'b1;
        fu_in[2] = mk(6'd50, 32'd50);
        tick();
        bm1 = 1'b0;
        fu_in = '0;
        check("s4_held_flushed", 64'(held_valid_debug), 64'd0);
        check("s4_cdb0_valid", 64'(CDB_0.valid), 64'd0);
        check("s4_cdb1_valid", 64'(CDB_1.valid), 64'd0);
        check("s4_rr_kept", 64'(rr_ptr_debug), 64'd2);
        tick();
        check("s4_no_late_cdb", 64'(CDB_0.valid), 64'd0);

        // Branch result carries mispredict and thread_id through.
        do_reset();
        fu_in[3] = mk(6'd7, 32'hDEAD);
        fu_in[3].mispredict = 1'b1;
        fu_in[3].thread_id  = 1'b1;
        fu_in[3].ROB_index  = 5'd9;
        tick();
        fu_in = '0;
        tick();
        check("s5_valid", 64'(CDB_0.valid), 64'd1);
        check("s5_mispredict", 64'(CDB_0.mispredict), 64'd1);
        check("s5_thread", 64'(CDB_0.thread_id), 64'd1);
        check("s5_rob", 64'(CDB_0.ROB_index), 64'd9);
        check("s5_prn", 64'(CDB_0.PRN), 64'd7);
        check("s5_rr", 64'(rr_ptr_debug), 64'd0);

        // Asynchronous reset between edges with all holds full.
        do_reset();
        for (int i = 0; i < 4; i++) fu_in[i] = mk(6'(60 + i), 32'(600 + i));
        tick();
        fu_in = '0;
        tick();
        check("s6_busy", 64'(CDB_0.valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("s6_cdb0_zero", 64'(CDB_0), 64'd0);
        check("s6_cdb1_zero", 64'(CDB_1), 64'd0);
        check("s6_ready", 64'(fu_ready), 64'hF);
        check("s6_held", 64'(held_valid_debug), 64'd0);
        check("s6_rr", 64'(rr_ptr_debug), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Schedules functional-unit completions onto the two common data buses (CDB_0, CDB_1) that feed the reservation station, ROB and PRF. Each of the four FUs (ALU0, ALU1, Mult, Branch) owns a one-entry holding register. Up to two held results are granted per cycle under rotating round-robin priority and driven out on registered CDB outputs. The block back-pressures FUs through per-FU ready bits and flushes all in-flight results on a branch mispredict.

## Interface
- NUM_FU, 4, number of requesters; index 0=ALU0, 1=ALU1, 2=Mult, 3=Branch.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- fu_result  in  CDB [NUM_FU-1:0]  per-FU completion; `.valid` marks a request; `FU_result/PRN/ROB_index/mispredict/thread_id` are payload.
- fu_ready  out  [NUM_FU-1:0]  FU may present a new result this cycle; combinational.
- branch_mispredict_0  in  1  flush request.
- branch_mispredict_1  in  1  flush request; either bit or both behave identically.
- CDB_0  out  CDB  first grant, registered.
- CDB_1  out  CDB  second grant, registered.
- held_valid_debug  out  [NUM_FU-1:0]  holding-register occupancy.
- rr_ptr_debug  out  [1:0]  current highest-priority FU index.

## Operation
- State:
  - hold[i]: CDB-typed register with valid bit.
  - rr_ptr: 2 bits.
  - CDB_0 and CDB_1 output registers.
- Ready: fu_ready[i] = !hold[i].valid || grant[i]. This lets an entry drain and refill in the same cycle.
- Capture: at posedge, if fu_result[i].valid && fu_ready[i] && no flush, then hold[i] <= fu_result[i].
  - fu_result[i].valid while fu_ready[i]=0 is a protocol violation. The FU must hold its result. The arbiter ignores that input.
- Pick, combinational over hold[*].valid:
  - first = the lowest circular index ≥ rr_ptr that is held.
  - second = the next held index circularly after first.
  - grant[first] and grant[second] are set only when those entries exist.
- Drive, at posedge:
  - CDB_0 <= hold[first] with valid=1, or valid=0 if nothing is held.
  - CDB_1 <= hold[second] with valid=1, or valid=0 if nothing is second.
  - Granted hold entries are cleared unless a new capture reloads them.
- Pointer:
  - Two grants: rr_ptr <= second+1 (mod 4).
  - One grant: rr_ptr <= first+1 (mod 4).
  - No grant: rr_ptr is unchanged.
- Flush (branch_mispredict_0 || branch_mispredict_1 at posedge):
  - All hold entries are cleared and no capture occurs.
  - CDB_0.valid and CDB_1.valid <= 0. Results presented that cycle are dropped.
  - rr_ptr is unchanged.
  - fu_ready still follows the formula above during the flush cycle.
- Payload fields of invalid CDB outputs: hold their previous value. Consumers qualify on valid only.

## Timing
- Reset values:
  - hold[*].valid=0, rr_ptr=0, fu_ready=4'b1111.
  - CDB_0 and CDB_1 are all-zero: valid=0, FU_result=0, PRN=0, ROB_index=0, mispredict=0, thread_id=0.
- Latency: a result accepted at edge N (with an uncontested pick) appears on a CDB after edge N+1. Minimum is 2 cycles from presentation to broadcast.
- Throughput:
  - 2 results per cycle sustained.
  - 4 simultaneous captures drain in 2 cycles.
  - An FU with a full, ungranted hold sees fu_ready=0 until it is granted.
- Fairness: any held entry is granted within 2 cycles. It is never at rotation distance >3, and two grants per cycle occur.
- Simultaneous grant and capture on the same i: new data is captured and the old data is broadcast; no bubble.
- Reset asserted mid-operation: all pending results are lost and outputs return to reset values asynchronously.
- A mispredict coincident with a CDB output already valid this cycle does not retract that output. Only next-edge loads are suppressed.

## Structure
- The shared package already holds the CDB struct. Add:
  - FU_ALU0, FU_ALU1, FU_MULT, FU_BRANCH index constants.
  - `NUM_FU`.
- Sub-module rr_pick2: purely combinational.
  - Inputs: 4-bit request vector and rr_ptr.
  - Outputs: first/second indices, first_valid/second_valid, and a 4-bit grant vector.
  - Instantiated once.
- The top holds the registers, ready logic, flush and output muxing.

## Test plan
- Reset, then ALU0 presents PRN=5, result=100 in one cycle → fu_ready=1111 throughout. CDB_0.valid=1, PRN=5, FU_result=100 two edges later. CDB_1.valid=0. rr_ptr=1.
- All four FUs present at once (PRNs 10,11,12,13), rr_ptr=0 → next-next edge CDB_0=10, CDB_1=11, rr_ptr=2. Following edge CDB_0=12, CDB_1=13, rr_ptr=0. fu_ready[2:3]=0 for exactly one cycle.
- Mult presents continuously each cycle while ALU0/ALU1/Branch present once → every held entry is broadcast within 2 cycles of capture. No fu_ready bit stays low more than 1 cycle.
- Fill all holds, then assert branch_mispredict_1 for one cycle → held_valid_debug=0000 and both CDB valids=0 after the edge. The rr_ptr value is preserved.
- Result on Branch with mispredict=1 and thread_id=1 → both fields are preserved on CDB_0.
- Drop reset low asynchronously between edges while holds are full → outputs zero immediately and fu_ready=1111.
